// File: rtl/mfp_avalon_mem_arbiter.sv
// Two-master, one-slave Avalon-MM arbiter for the LPDDR2 controller port.
// Round-robin grant held for a whole write burst or a read command plus all of its return beats.
`timescale 1ns/1ps
module mfp_avalon_mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BURST_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   m0_address,
  input  logic                    m0_read,
  input  logic                    m0_write,
  input  logic [DATA_WIDTH-1:0]   m0_writedata,
  input  logic [DATA_WIDTH/8-1:0] m0_byteenable,
  input  logic [BURST_WIDTH-1:0]  m0_burstcount,
  output logic                    m0_waitrequest,
  output logic [DATA_WIDTH-1:0]   m0_readdata,
  output logic                    m0_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   m1_address,
  input  logic                    m1_read,
  input  logic                    m1_write,
  input  logic [DATA_WIDTH-1:0]   m1_writedata,
  input  logic [DATA_WIDTH/8-1:0] m1_byteenable,
  input  logic [BURST_WIDTH-1:0]  m1_burstcount,
  output logic                    m1_waitrequest,
  output logic [DATA_WIDTH-1:0]   m1_readdata,
  output logic                    m1_readdatavalid,
  output logic [ADDR_WIDTH-1:0]   s_address,
  output logic                    s_read,
  output logic                    s_write,
  output logic [DATA_WIDTH-1:0]   s_writedata,
  output logic [DATA_WIDTH/8-1:0] s_byteenable,
  output logic [BURST_WIDTH-1:0]  s_burstcount,
  output logic                    s_beginbursttransfer,
  input  logic                    s_waitrequest,
  input  logic [DATA_WIDTH-1:0]   s_readdata,
  input  logic                    s_readdatavalid,
  output logic                    err_stray_rdv
);

  typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD_CMD, ST_RD_DATA} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   r_owner;
  logic                   r_last_grant;
  logic                   r_first;
  logic                   r_err_stray;
  logic [BURST_WIDTH-1:0] r_beats_left;

  logic                   w_req0, w_req1, w_any_req;
  logic                   w_grant;
  logic                   w_grant_read;
  logic [BURST_WIDTH-1:0] w_grant_burst;
  logic                   w_own_read, w_own_write;
  logic                   w_s_read, w_s_write, w_bbt;
  logic                   w_cmd_phase, w_data_phase;
  logic                   w_wr_accept, w_rd_accept, w_rdv_beat, w_last_beat;
  logic [1:0]             w_wait, w_rdv;

  assign w_req0    = m0_read | m0_write;
  assign w_req1    = m1_read | m1_write;
  assign w_any_req = w_req0 | w_req1;
  // On a tie the master that did not finish the previous transaction wins.
  assign w_grant       = (w_req0 && w_req1) ? ~r_last_grant : w_req1;
  assign w_grant_read  = w_grant ? m1_read : m0_read;
  assign w_grant_burst = w_grant ? m1_burstcount : m0_burstcount;

  assign w_own_read   = r_owner ? m1_read  : m0_read;
  assign w_own_write  = r_owner ? m1_write : m0_write;
  assign s_address    = r_owner ? m1_address    : m0_address;
  assign s_writedata  = r_owner ? m1_writedata  : m0_writedata;
  assign s_byteenable = r_owner ? m1_byteenable : m0_byteenable;
  assign s_burstcount = r_owner ? m1_burstcount : m0_burstcount;

  assign w_wr_accept = w_s_write & ~s_waitrequest;
  assign w_rd_accept = w_s_read & ~s_waitrequest;
  assign w_rdv_beat  = w_data_phase & s_readdatavalid;
  assign w_last_beat = (r_beats_left <= BURST_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_any_req) w_state_next = w_grant_read ? ST_RD_CMD : ST_WR;
      ST_WR:      if (w_wr_accept && w_last_beat) w_state_next = ST_IDLE;
      ST_RD_CMD:  if (w_rd_accept) w_state_next = ST_RD_DATA;
      ST_RD_DATA: if (w_rdv_beat && w_last_beat) w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_s_read     = 1'b0;
    w_s_write    = 1'b0;
    w_bbt        = 1'b0;
    w_cmd_phase  = 1'b0;
    w_data_phase = 1'b0;
    case (r_state)
      ST_WR: begin
        w_s_write   = w_own_write;
        w_bbt       = r_first;
        w_cmd_phase = 1'b1;
      end
      ST_RD_CMD: begin
        w_s_read    = w_own_read;
        w_bbt       = r_first;
        w_cmd_phase = 1'b1;
      end
      ST_RD_DATA: w_data_phase = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_first      <= 1'b0;
      r_err_stray  <= 1'b0;
      r_beats_left <= '0;
    end else begin
      r_first     <= (r_state == ST_IDLE) && w_any_req;
      r_err_stray <= s_readdatavalid && (r_state != ST_RD_DATA);
      case (r_state)
        ST_IDLE: if (w_any_req) begin
          r_owner      <= w_grant;
          r_beats_left <= (w_grant_burst == '0) ? BURST_WIDTH'(1) : w_grant_burst;
        end
        ST_WR: if (w_wr_accept) begin
          r_beats_left <= r_beats_left - BURST_WIDTH'(1);
          if (w_last_beat) r_last_grant <= r_owner;
        end
        ST_RD_DATA: if (w_rdv_beat) begin
          r_beats_left <= r_beats_left - BURST_WIDTH'(1);
          if (w_last_beat) r_last_grant <= r_owner;
        end
        default: ;
      endcase
    end
  end

  // Only the owner sees the slave's stall, and only while its command is on the bus.
  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    assign w_wait[gi] = (w_cmd_phase && (r_owner == 1'(gi))) ? s_waitrequest : 1'b1;
    assign w_rdv[gi]  = w_rdv_beat && (r_owner == 1'(gi));
  end

  assign m0_waitrequest       = w_wait[0];
  assign m1_waitrequest       = w_wait[1];
  assign m0_readdatavalid     = w_rdv[0];
  assign m1_readdatavalid     = w_rdv[1];
  assign m0_readdata          = s_readdata;
  assign m1_readdata          = s_readdata;
  assign s_read               = w_s_read;
  assign s_write              = w_s_write;
  assign s_beginbursttransfer = w_bbt;
  assign err_stray_rdv        = r_err_stray;

endmodule

// File: tb/tb_mfp_avalon_mem_arbiter.sv
// Scoreboard bench for mfp_avalon_mem_arbiter: expected commands, write beats and read beats are
// queued as masters are driven and popped as the slave side / owning master observes them.
`timescale 1ns/1ps
module tb_mfp_avalon_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] m0_address = '0, m1_address = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic [2:0]  m0_burstcount = '0, m1_burstcount = '0;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [31:0] s_address, s_writedata;
  logic        s_read, s_write, s_beginbursttransfer;
  logic [3:0]  s_byteenable;
  logic [2:0]  s_burstcount;
  logic        s_waitrequest = 1'b0;
  logic [31:0] s_readdata = '0;
  logic        s_readdatavalid = 1'b0;
  logic        err_stray_rdv;

  mfp_avalon_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable), .m0_burstcount(m0_burstcount),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable), .m1_burstcount(m1_burstcount),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable), .s_burstcount(s_burstcount),
    .s_beginbursttransfer(s_beginbursttransfer), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid), .err_stray_rdv(err_stray_rdv)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int err_cnt  = 0;

  logic [35:0] exp_cmd[$];    // {write, address, burstcount}
  logic [63:0] exp_wbeat[$];  // {address, writedata}
  logic [32:0] exp_rbeat[$];  // {master, readdata}
  logic [31:0] rsp_q[$];
  int          rsp_gap = 0;
  bit          stray_req = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic int beats_of(input logic [2:0] burst);
    return (burst == 3'd0) ? 1 : int'(burst);
  endfunction

  task automatic exp_write(input logic [31:0] addr, input logic [2:0] burst, input logic [31:0] dbase);
    exp_cmd.push_back({1'b1, addr, burst});
    for (int i = 0; i < beats_of(burst); i++) exp_wbeat.push_back({addr, dbase + 32'(i)});
  endtask

  task automatic exp_read(input int n, input logic [31:0] addr, input logic [2:0] burst);
    exp_cmd.push_back({1'b0, addr, burst});
    for (int i = 0; i < beats_of(burst); i++) exp_rbeat.push_back({1'(n), addr + 32'(i)});
  endtask

  task automatic drive_m(input int n, input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [2:0] burst, input logic [31:0] data);
    if (n == 0) begin
      m0_read = rd; m0_write = wr; m0_address = addr; m0_burstcount = burst;
      m0_writedata = data; m0_byteenable = 4'hF;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = addr; m1_burstcount = burst;
      m1_writedata = data; m1_byteenable = 4'hF;
    end
  endtask

  // Returns one tick after the clock edge at which the master's request was accepted.
  task automatic wait_accept(input int n, output bit ok);
    ok = 1'b0;
    for (int g = 0; g < 200 && !ok; g++) begin
      @(negedge clk);
      ok = (n == 0) ? !m0_waitrequest : !m1_waitrequest;
      @(posedge clk); #1;
    end
  endtask

  task automatic mwrite(input int n, input logic [31:0] addr, input logic [2:0] burst,
                        input logic [31:0] dbase);
    int sent = 0;
    bit ok;
    drive_m(n, 1'b0, 1'b1, addr, burst, dbase);
    for (int b = 0; b < beats_of(burst); b++) begin
      wait_accept(n, ok);
      if (!ok) break;
      sent++;
      if (sent < beats_of(burst)) drive_m(n, 1'b0, 1'b1, addr, burst, dbase + 32'(sent));
    end
    drive_m(n, 1'b0, 1'b0, '0, '0, '0);
    chk("wr_beats_accepted", 64'(sent), 64'(beats_of(burst)));
  endtask

  task automatic mread(input int n, input logic [31:0] addr, input logic [2:0] burst);
    int got = 0;
    bit ok;
    drive_m(n, 1'b1, 1'b0, addr, burst, '0);
    wait_accept(n, ok);
    drive_m(n, 1'b0, 1'b0, '0, '0, '0);
    chk("rd_cmd_accepted", 64'(ok), 64'd1);
    for (int g = 0; g < 200 && got < beats_of(burst); g++) begin
      @(negedge clk);
      if ((n == 0) ? m0_readdatavalid : m1_readdatavalid) got++;
    end
    chk("rd_beats_received", 64'(got), 64'(beats_of(burst)));
  endtask

  // Monitor: pops the scoreboard on every observed command, write beat and read beat.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (s_beginbursttransfer) begin
        chk("cmd_expected", 64'(exp_cmd.size() != 0), 64'd1);
        if (exp_cmd.size() != 0) begin
          chk("cmd", 64'({s_write, s_address, s_burstcount}), 64'(exp_cmd.pop_front()));
          $display("cmd  wr=%0d rd=%0d addr=%h burst=%0d", s_write, s_read, s_address, s_burstcount);
        end
      end
      if (s_write && !s_waitrequest) begin
        chk("wbeat_expected", 64'(exp_wbeat.size() != 0), 64'd1);
        if (exp_wbeat.size() != 0) chk("wbeat", {s_address, s_writedata}, exp_wbeat.pop_front());
      end
      if (s_read && !s_waitrequest) begin
        for (int i = 0; i < beats_of(s_burstcount); i++) rsp_q.push_back(s_address + 32'(i));
        rsp_gap = 2;
      end
      if (m0_readdatavalid || m1_readdatavalid) begin
        chk("rdv_onehot", 64'(m0_readdatavalid & m1_readdatavalid), 64'd0);
        chk("rbeat_expected", 64'(exp_rbeat.size() != 0), 64'd1);
        if (exp_rbeat.size() != 0)
          chk("rbeat", 64'({m1_readdatavalid, m1_readdatavalid ? m1_readdata : m0_readdata}),
              64'(exp_rbeat.pop_front()));
      end
      if (err_stray_rdv) err_cnt++;
    end
  end

  // Slave model: returns read beats (data = beat address) two cycles after command acceptance.
  initial forever begin
    @(posedge clk); #1;
    if (rst) begin
      rsp_q.delete(); rsp_gap = 0; s_readdatavalid = 1'b0;
    end else if (stray_req) begin
      s_readdatavalid = 1'b1; s_readdata = 32'hBAD0_0000; stray_req = 1'b0;
    end else if (rsp_gap > 0) begin
      rsp_gap--; s_readdatavalid = 1'b0;
    end else if (rsp_q.size() != 0) begin
      s_readdatavalid = 1'b1; s_readdata = rsp_q.pop_front();
    end else begin
      s_readdatavalid = 1'b0;
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_m0_wait"}, 64'(m0_waitrequest), 64'd1);
    chk({tag, "_m1_wait"}, 64'(m1_waitrequest), 64'd1);
    chk({tag, "_s_strobes"}, 64'({s_read, s_write, s_beginbursttransfer}), 64'd0);
    chk({tag, "_rdv"}, 64'({m0_readdatavalid, m1_readdatavalid}), 64'd0);
    chk({tag, "_err"}, 64'(err_stray_rdv), 64'd0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    bit ok;
    int got;
    // Test 1: m0 write burst of 4 with no slave stall
    reset_dut();
    exp_write(32'h0000_1000, 3'd4, 32'hA000_0000);
    drive_m(0, 1'b0, 1'b1, 32'h0000_1000, 3'd4, 32'hA000_0000);
    @(negedge clk);
    chk("t1_req_cycle_wait", 64'(m0_waitrequest), 64'd1);
    chk("t1_req_cycle_swrite", 64'(s_write), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_beat1_bbt", 64'(s_beginbursttransfer), 64'd1);
    chk("t1_beat1_wait", 64'(m0_waitrequest), 64'd0);
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      drive_m(0, 1'b0, 1'b1, 32'h0000_1000, 3'd4, 32'hA000_0000 + 32'(k));
      @(negedge clk);
      chk("t1_beat_bbt_low", 64'(s_beginbursttransfer), 64'd0);
      chk("t1_beat_swrite", 64'(s_write), 64'd1);
    end
    @(posedge clk); #1;
    drive_m(0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("t1_idle_at_T5", 64'(m0_waitrequest), 64'd1);

    // Test 2: simultaneous reads, m0 wins the tie after reset
    reset_dut();
    exp_read(0, 32'h0000_2000, 3'd2);
    exp_read(1, 32'h0000_2100, 3'd2);
    fork
      mread(0, 32'h0000_2000, 3'd2);
      mread(1, 32'h0000_2100, 3'd2);
    join

    // Test 3: both masters request continuously, grants alternate m0,m1,...
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      exp_write(32'h0000_3000 + 32'(k * 16), 3'd1, 32'h3000_0000 + 32'(k));
      exp_write(32'h0000_3100 + 32'(k * 16), 3'd1, 32'h3100_0000 + 32'(k));
    end
    fork
      for (int k = 0; k < 3; k++) mwrite(0, 32'h0000_3000 + 32'(k * 16), 3'd1, 32'h3000_0000 + 32'(k));
      for (int k = 0; k < 3; k++) mwrite(1, 32'h0000_3100 + 32'(k * 16), 3'd1, 32'h3100_0000 + 32'(k));
    join

    // Test 4: slave stalls beat 2 of a 4-beat write for 3 cycles
    @(posedge clk); #1;
    exp_write(32'h0000_4000, 3'd4, 32'h4000_0000);
    fork
      mwrite(0, 32'h0000_4000, 3'd4, 32'h4000_0000);
      begin
        ok = 1'b0;
        for (int g = 0; g < 50 && !ok; g++) begin
          @(negedge clk);
          ok = s_write && !s_waitrequest;
        end
        chk("t4_first_beat_seen", 64'(ok), 64'd1);
        @(posedge clk); #1;
        s_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("t4_hold_swrite", 64'(s_write), 64'd1);
          chk("t4_hold_wait", 64'(m0_waitrequest), 64'd1);
          chk("t4_hold_data", 64'(s_writedata), 64'h4000_0001);
          @(posedge clk); #1;
        end
        s_waitrequest = 1'b0;
      end
    join

    // Test 5: burstcount 0 read behaves as one beat, then a stray readdatavalid in IDLE
    @(posedge clk); #1;
    exp_read(1, 32'h0000_5000, 3'd0);
    mread(1, 32'h0000_5000, 3'd0);
    @(posedge clk); #2;
    chk("t5_idle_after_single", 64'(m1_waitrequest), 64'd1);
    stray_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_stray_driven", 64'(s_readdatavalid), 64'd1);
    chk("t5_err_before", 64'(err_stray_rdv), 64'd0);
    @(negedge clk);
    chk("t5_err_pulse", 64'(err_stray_rdv), 64'd1);
    @(negedge clk);
    chk("t5_err_after", 64'(err_stray_rdv), 64'd0);

    // Test 6: reset during RD_DATA with 3 beats outstanding
    @(posedge clk); #1;
    exp_cmd.push_back({1'b0, 32'h0000_6000, 3'd4});
    exp_rbeat.push_back({1'b0, 32'h0000_6000});
    drive_m(0, 1'b1, 1'b0, 32'h0000_6000, 3'd4, '0);
    wait_accept(0, ok);
    drive_m(0, 1'b0, 1'b0, '0, '0, '0);
    chk("t6_cmd_accepted", 64'(ok), 64'd1);
    got = 0;
    for (int g = 0; g < 50 && got == 0; g++) begin
      @(negedge clk);
      if (m0_readdatavalid) got = 1;
    end
    chk("t6_first_rdv_seen", 64'(got), 64'd1);
    #1 rst = 1'b1;
    #1 check_idle_outputs("t6_in_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    exp_read(0, 32'h0000_7000, 3'd1);
    exp_read(1, 32'h0000_7100, 3'd1);
    fork
      mread(0, 32'h0000_7000, 3'd1);
      mread(1, 32'h0000_7100, 3'd1);
    join

    repeat (3) @(posedge clk);
    chk("cmd_q_drained", 64'(exp_cmd.size()), 64'd0);
    chk("wbeat_q_drained", 64'(exp_wbeat.size()), 64'd0);
    chk("rbeat_q_drained", 64'(exp_rbeat.size()), 64'd0);
    chk("err_pulse_total", 64'(err_cnt), 64'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
